// File: rtl/os_mac_array_tiled_if.sv
// Run-control, operand-stream and result-drain signals of os_mac_array_tiled.
// The bench/DMA side uses the master modport, the array uses slave.
interface os_mac_array_tiled_if #(
  parameter int A_H       = 4,
  parameter int B_W       = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int K_MAX     = 256
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int IW = (A_H > 1) ? $clog2(A_H) : 1;

  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     acc_mode;
  logic                     signed_mode;
  logic                     in_valid;
  logic                     in_ready;
  logic [A_H*WIDTH-1:0]     a_col;
  logic [B_W*WIDTH-1:0]     b_row;
  logic                     out_valid;
  logic                     out_ready;
  logic [B_W*ACC_WIDTH-1:0] out_row;
  logic [IW-1:0]            out_idx;
  logic                     out_last;
  logic                     busy;

  modport master (
    output start, k_len, acc_mode, signed_mode, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_idx, out_last, busy
  );

  modport slave (
    input  start, k_len, acc_mode, signed_mode, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_idx, out_last, busy
  );
endinterface

// File: rtl/os_mac_array_tiled.sv
// Output-stationary MAC array with internal operand skew, K-tile accumulation and row drain.
// Optional macro OS_ARRAY_SAT_EN: saturating accumulate instead of two's-complement wrap.
module os_mac_array_tiled #(
  parameter int A_H       = 4,
  parameter int B_W       = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int K_MAX     = 256
) (
  input logic                clk,
  input logic                rst_n,
  os_mac_array_tiled_if.slave io
);
  localparam int KW        = $clog2(K_MAX + 1);
  localparam int IW        = (A_H > 1) ? $clog2(A_H) : 1;
  localparam int FLUSH_LEN = A_H + B_W - 1;
  localparam int FW        = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t                   r_state;
  logic [KW-1:0]            r_k_len, r_cnt;
  logic [FW-1:0]            r_fcnt;
  logic                     r_signed, r_in_ready, r_out_valid, r_out_last, r_busy;
  logic [B_W*ACC_WIDTH-1:0] r_out_row;
  logic [IW-1:0]            r_out_idx;

  logic                     w_beat, w_clr;
  logic [IW-1:0]            w_next_idx;
  logic [B_W*ACC_WIDTH-1:0] w_next_row;

  logic [WIDTH-1:0]     w_a_sk  [A_H];
  logic                 w_av_sk [A_H];
  logic [WIDTH-1:0]     w_b_sk  [B_W];
  logic                 w_bv_sk [B_W];
  logic [WIDTH-1:0]     w_a_out  [A_H][B_W];
  logic                 w_av_out [A_H][B_W];
  logic [WIDTH-1:0]     w_b_out  [A_H][B_W];
  logic                 w_bv_out [A_H][B_W];
  logic [ACC_WIDTH-1:0] w_acc    [A_H][B_W];

  assign w_beat = io.in_valid && r_in_ready;
  assign w_clr  = (r_state == S_IDLE) && io.start && !io.acc_mode;

`ifdef OS_ARRAY_SAT_EN
  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [ACC_WIDTH-1:0] p,
                                                   input logic sgn);
    logic [ACC_WIDTH:0] s;
    if (sgn) begin
      s = {acc[ACC_WIDTH-1], acc} + {p[ACC_WIDTH-1], p};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
        return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      return s[ACC_WIDTH-1:0];
    end
    s = {1'b0, acc} + {1'b0, p};
    return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
  endfunction
`endif

  // Lane i of A / lane j of B is delayed i / j cycles so wavefronts meet on the diagonal.
  for (genvar i = 0; i < A_H; i++) begin : g_askew
    if (i == 0) begin : g_direct
      assign w_a_sk[i]  = io.a_col[i*WIDTH +: WIDTH];
      assign w_av_sk[i] = w_beat;
    end else begin : g_delay
      logic [WIDTH-1:0] r_d  [i];
      logic             r_dv [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < i; k++) begin r_d[k] <= '0; r_dv[k] <= 1'b0; end
        end else begin
          r_d[0]  <= io.a_col[i*WIDTH +: WIDTH];
          r_dv[0] <= w_beat;
          for (int unsigned k = 1; k < i; k++) begin r_d[k] <= r_d[k-1]; r_dv[k] <= r_dv[k-1]; end
        end
      end
      assign w_a_sk[i]  = r_d[i-1];
      assign w_av_sk[i] = r_dv[i-1];
    end
  end

  for (genvar j = 0; j < B_W; j++) begin : g_bskew
    if (j == 0) begin : g_direct
      assign w_b_sk[j]  = io.b_row[j*WIDTH +: WIDTH];
      assign w_bv_sk[j] = w_beat;
    end else begin : g_delay
      logic [WIDTH-1:0] r_d  [j];
      logic             r_dv [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < j; k++) begin r_d[k] <= '0; r_dv[k] <= 1'b0; end
        end else begin
          r_d[0]  <= io.b_row[j*WIDTH +: WIDTH];
          r_dv[0] <= w_beat;
          for (int unsigned k = 1; k < j; k++) begin r_d[k] <= r_d[k-1]; r_dv[k] <= r_dv[k-1]; end
        end
      end
      assign w_b_sk[j]  = r_d[j-1];
      assign w_bv_sk[j] = r_dv[j-1];
    end
  end

  for (genvar i = 0; i < A_H; i++) begin : g_row
    for (genvar j = 0; j < B_W; j++) begin : g_col
      logic [WIDTH-1:0]     r_a, r_b, w_ain, w_bin;
      logic                 r_av, r_bv, w_ainv, w_binv;
      logic [ACC_WIDTH-1:0] r_acc, w_ax, w_bx, w_p;

      if (j == 0) begin : g_ain
        assign w_ain  = w_a_sk[i];
        assign w_ainv = w_av_sk[i];
      end else begin : g_ain_pe
        assign w_ain  = w_a_out[i][j-1];
        assign w_ainv = w_av_out[i][j-1];
      end
      if (i == 0) begin : g_bin
        assign w_bin  = w_b_sk[j];
        assign w_binv = w_bv_sk[j];
      end else begin : g_bin_pe
        assign w_bin  = w_b_out[i-1][j];
        assign w_binv = w_bv_out[i-1][j];
      end

      // Extending both operands to ACC_WIDTH first gives the exact product modulo 2^ACC_WIDTH.
      assign w_ax = r_signed ? ACC_WIDTH'($signed(w_ain)) : ACC_WIDTH'(w_ain);
      assign w_bx = r_signed ? ACC_WIDTH'($signed(w_bin)) : ACC_WIDTH'(w_bin);
      assign w_p  = w_ax * w_bx;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0; r_b <= '0; r_av <= 1'b0; r_bv <= 1'b0; r_acc <= '0;
        end else begin
          r_a  <= w_ain;  r_av <= w_ainv;
          r_b  <= w_bin;  r_bv <= w_binv;
          if (w_clr) r_acc <= '0;
          else if (w_ainv && w_binv) begin
`ifdef OS_ARRAY_SAT_EN
            r_acc <= acc_add(r_acc, w_p, r_signed);
`else
            r_acc <= r_acc + w_p;
`endif
          end
        end
      end

      assign w_a_out[i][j]  = r_a;
      assign w_av_out[i][j] = r_av;
      assign w_b_out[i][j]  = r_b;
      assign w_bv_out[i][j] = r_bv;
      assign w_acc[i][j]    = r_acc;
    end
  end

  always_comb begin
    w_next_idx = (r_state == S_DRAIN) ? r_out_idx + IW'(1) : '0;
    w_next_row = '0;
    for (int unsigned j = 0; j < B_W; j++) w_next_row[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[w_next_idx][j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE; r_k_len <= '0; r_cnt <= '0; r_fcnt <= '0; r_signed <= 1'b0;
      r_in_ready <= 1'b0; r_out_valid <= 1'b0; r_out_row <= '0; r_out_idx <= '0;
      r_out_last <= 1'b0; r_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (io.start) begin
          r_k_len <= io.k_len; r_signed <= io.signed_mode;
          r_cnt <= '0; r_fcnt <= '0; r_busy <= 1'b1;
          if (io.k_len == '0) r_state <= S_FLUSH;
          else begin r_state <= S_LOAD; r_in_ready <= 1'b1; end
        end
        S_LOAD: if (w_beat) begin
          r_cnt <= r_cnt + KW'(1);
          if (r_cnt + KW'(1) == r_k_len) begin r_state <= S_FLUSH; r_in_ready <= 1'b0; end
        end
        S_FLUSH: if (r_fcnt == FW'(FLUSH_LEN - 1)) begin
          r_state <= S_DRAIN; r_out_valid <= 1'b1; r_out_idx <= '0;
          r_out_last <= (A_H == 1); r_out_row <= w_next_row;
        end else r_fcnt <= r_fcnt + FW'(1);
        S_DRAIN: if (io.out_ready) begin
          if (r_out_last) begin
            r_state <= S_IDLE; r_out_valid <= 1'b0; r_out_last <= 1'b0;
            r_out_idx <= '0; r_out_row <= '0; r_busy <= 1'b0;
          end else begin
            r_out_idx <= w_next_idx; r_out_row <= w_next_row;
            r_out_last <= (int'(w_next_idx) == A_H - 1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = r_in_ready;
  assign io.out_valid = r_out_valid;
  assign io.out_row   = r_out_row;
  assign io.out_idx   = r_out_idx;
  assign io.out_last  = r_out_last;
  assign io.busy      = r_busy;
endmodule

// File: doc/os_mac_array_tiled.md
# os_mac_array_tiled

Output-stationary signed/unsigned MAC systolic array with built-in operand skewing, K-tile accumulation and a row-by-row result drain over a valid/ready handshake. It is the next generation of the team's OS MAC array. The external bench or DMA no longer pre-skews operands or samples the full result bus; it streams unskewed A columns and B rows, then pops C[A_H,B_W] one row at a time. It sits between the operand buffers and the result writeback path.

## Interface
- A_H, 4: array rows (M tile).
- B_W, 4: array columns (N tile).
- WIDTH, 8: operand width.
- ACC_WIDTH, 32: accumulator width, at least 2*WIDTH.
- K_MAX, 256: maximum beats per run. KW = $clog2(K_MAX+1).
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a run; sampled only in IDLE.
- k_len, input, KW: number of beats in the run; latched on start.
- acc_mode, input, 1: 1 = keep accumulators from the previous run (K-tiling); 0 = clear them. Latched on start.
- signed_mode, input, 1: 1 = operands are signed; 0 = operands are unsigned. Latched on start.
- in_valid, input, 1: beat valid.
- in_ready, output, 1: high only in LOAD.
- a_col, input, A_H*WIDTH: A[0..A_H-1][k]; lane i is at [i*WIDTH +: WIDTH].
- b_row, input, B_W*WIDTH: B[k][0..B_W-1].
- out_valid, output, 1: result row valid.
- out_ready, input, 1: result row accepted.
- out_row, output, B_W*ACC_WIDTH: C[r][0..B_W-1].
- out_idx, output, $clog2(A_H): row index r.
- out_last, output, 1: high with out_valid when r = A_H-1.
- busy, output, 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, LOAD, FLUSH and DRAIN.
- IDLE to LOAD: on start. If acc_mode=0, all accumulators clear on the same edge.
  - If k_len=0, the FSM goes to FLUSH instead.
- LOAD:
  - A beat transfers when in_valid && in_ready.
  - A beat counter reaches k_len, then the FSM goes to FLUSH on that edge.
  - Idle cycles (in_valid=0) inject bubbles.
- Skew: lane i of A is delayed i cycles and lane j of B is delayed j cycles through internal shift registers. Each operand carries a valid bit.
- PE(i,j): passes a to the right and b downward through one register each.
  - When the a and b valid bits are both set, it computes acc += ext(a)*ext(b).
  - ext() is sign extension when signed_mode=1 and zero extension otherwise.
  - The product is 2*WIDTH bits, extended to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH, except as described under Configuration.
- FLUSH: lasts exactly A_H+B_W-1 cycles, then the FSM goes to DRAIN with r=0.
- DRAIN: out_valid=1 and out_row = acc[r][*].
  - On out_valid && out_ready, r increments.
  - The handshake with out_last=1 returns the FSM to IDLE.
  - Accumulators are not cleared by DRAIN.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.

## Timing
- Reset values: in_ready=0, out_valid=0, out_row=0, out_idx=0, out_last=0, busy=0, all accumulators=0, FSM=IDLE.
- Reset asserted mid-run aborts the run to these values immediately (asynchronous).
- start is sampled at edge T. in_ready is 1 from T+1.
- The last accepted beat at edge L gives FLUSH from L+1 and first out_valid at L+A_H+B_W.
- Minimum run with no stalls: 1 (start) + k_len + (A_H+B_W-1) + A_H cycles.
- out_row, out_idx and out_last are registered and stay stable while out_valid && !out_ready.
- busy goes low on the edge after the final pop. start can be accepted on the following cycle.

## Configuration
- OS_ARRAY_SAT_EN:
  - Defined: each accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] when signed_mode=1, and to [0, 2^ACC_WIDTH-1] when signed_mode=0.
  - Undefined: two's-complement wrap. No saturation logic is built.

## Test plan
All scenarios use A_H=B_W=4, WIDTH=8, ACC_WIDTH=32 unless stated otherwise.
- Identity: A=I4, B[k][j]=10k+j, k_len=4, signed_mode=1 -> rows pop in order r=0..3 and equal B[r]; out_last only on r=3; first out_valid 8 cycles after the last beat.
- Signed extremes: all A=B=-128, k_len=4 -> every element is 65536; with signed_mode=0 (0x80 treated as 128) every element is also 65536. With A=B=0xFF and k_len=2: signed gives 2, unsigned gives 130050.
- K-tiling: run 1 with k_len=2 and acc_mode=0, then run 2 with k_len=2 and acc_mode=1 using the second half of the K=4 data -> the run-2 drain equals the full K=4 golden product.
- Stalls: in_valid low on every other beat, out_ready low for 3 cycles on row 1 -> results still match golden; out_row and out_idx are held during the stall; in_ready=0 outside LOAD.
- Reset and edges:
  - rst_n pulsed mid-LOAD -> all outputs 0 and IDLE; the next run is correct.
  - start during DRAIN -> ignored.
  - k_len=0 with acc_mode=0 -> 4 rows of zeros.
- Saturation with ACC_WIDTH=16, A=B=127, k_len=4 (true sum 64516):
  - OS_ARRAY_SAT_EN defined -> 32767.
  - OS_ARRAY_SAT_EN undefined -> -1020.
